// File: rtl/addrc_controller.sv
// addrc_controller: sequencer for the addRC datapath.
// For each accepted start it walks file_count consecutive state files and,
// for every line of every file, issues read / register-load / write strobes
// on three consecutive cycles. All outputs are registered (Moore).
module addrc_controller #(
  parameter int LINES  = 64,
  parameter int FILE_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FILE_W-1:0] base_file,
  input  logic [FILE_W-1:0] file_count,
  input  logic [4:0]        round,
  output logic              read_file,
  output logic              write_reg,
  output logic              write_file,
  output logic [FILE_W-1:0] file_index,
  output logic [5:0]        line_index,
  output logic [4:0]        iteration,
  output logic              busy,
  output logic              done
);

  localparam logic [5:0]        LAST_LINE = 6'(LINES - 1);
  localparam logic [FILE_W-1:0] ONE_F     = FILE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [FILE_W-1:0] r_remaining;
  logic [FILE_W-1:0] r_file_index;
  logic [5:0]        r_line_index;
  logic [4:0]        r_iteration;
  logic              r_read;
  logic              r_wreg;
  logic              r_wfile;
  logic              r_busy;
  logic              r_done;

  // Strobes, busy and done are loaded together with the next state so each
  // output is a flop that is high exactly while the FSM sits in its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_file_index <= '0;
      r_line_index <= '0;
      r_iteration  <= '0;
      r_read       <= 1'b0;
      r_wreg       <= 1'b0;
      r_wfile      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_file_index <= base_file;
            r_remaining  <= file_count;
            r_iteration  <= round;
            r_line_index <= '0;
            r_busy       <= 1'b1;
            if (file_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_read  <= 1'b1;
            end
          end
        end

        S_READ: begin
          r_read  <= 1'b0;
          r_wreg  <= 1'b1;
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          r_wreg  <= 1'b0;
          r_wfile <= 1'b1;
          r_state <= S_WRITE;
        end

        S_WRITE: begin
          r_wfile <= 1'b0;
          if (r_line_index < LAST_LINE) begin
            r_line_index <= r_line_index + 6'd1;
            r_read       <= 1'b1;
            r_state      <= S_READ;
          end else begin
            r_line_index <= '0;
            r_remaining  <= r_remaining - ONE_F;
            // remaining == 1 here means it becomes zero after this file
            if (r_remaining != ONE_F) begin
              r_file_index <= r_file_index + ONE_F;
              r_read       <= 1'b1;
              r_state      <= S_READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_read  <= 1'b0;
          r_wreg  <= 1'b0;
          r_wfile <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign read_file  = r_read;
  assign write_reg  = r_wreg;
  assign write_file = r_wfile;
  assign file_index = r_file_index;
  assign line_index = r_line_index;
  assign iteration  = r_iteration;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_addrc_controller.sv
// Testbench for addrc_controller: scoreboard of expected strobe events with
// their absolute observation cycle, compared as the DUT emits them.
module tb_addrc_controller;

  localparam int LINES  = 64;
  localparam int FILE_W = 10;
  localparam int FMOD   = 1 << FILE_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [FILE_W-1:0] base_file;
  logic [FILE_W-1:0] file_count;
  logic [4:0]        round;
  logic              read_file;
  logic              write_reg;
  logic              write_file;
  logic [FILE_W-1:0] file_index;
  logic [5:0]        line_index;
  logic [4:0]        iteration;
  logic              busy;
  logic              done;

  addrc_controller #(.LINES(LINES), .FILE_W(FILE_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_file  (base_file),
    .file_count (file_count),
    .round      (round),
    .read_file  (read_file),
    .write_reg  (write_reg),
    .write_file (write_file),
    .file_index (file_index),
    .line_index (line_index),
    .iteration  (iteration),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 read, 1 load, 2 write, 3 done
    int cyc;
    int file;
    int line;
    int iter;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  wcount   = 0;
  bit  mon_en   = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue the full expected event list of a batch; stop after max_ev events
  // (negative = no limit) when the batch is going to be aborted.
  task automatic push_batch(input int t, input int base, input int n,
                            input int iter, input int max_ev);
    int cnt;
    ev_t e;
    cnt = 0;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < LINES; k++) begin
        for (int s = 0; s < 3; s++) begin
          if (max_ev >= 0 && cnt >= max_ev) return;
          e.kind = s;
          e.cyc  = t + 3 * LINES * j + 3 * k + s;
          e.file = (base + j) % FMOD;
          e.line = k;
          e.iter = iter;
          q.push_back(e);
          cnt++;
        end
      end
    end
    if (max_ev >= 0 && cnt >= max_ev) return;
    e.kind = 3;
    e.cyc  = t + 3 * LINES * n;
    e.file = (n == 0) ? base : (base + n - 1) % FMOD;
    e.line = 0;
    e.iter = iter;
    q.push_back(e);
  endtask

  // Pulse start for one cycle; returns the edge number at which it is sampled.
  task automatic run_start(input int base, input int n, input int iter, output int t);
    @(negedge clk);
    base_file  = FILE_W'(base);
    file_count = FILE_W'(n);
    round      = 5'(iter);
    start      = 1'b1;
    t = cyc + 1;
    push_batch(t, base, n, iter, -1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
  endtask

  // Monitor: every strobe/done cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    int nh;
    int ok;
    ev_t e;
    if (mon_en) begin
      nh = int'(read_file) + int'(write_reg) + int'(write_file) + int'(done);
      if (write_file) wcount++;
      if (nh != 0) begin
        chk("onehot", nh, 1);
        ok = read_file ? 0 : write_reg ? 1 : write_file ? 2 : 3;
        if (q.size() == 0) begin
          chk("spurious_ev", ok, -1);
        end else begin
          e = q.pop_front();
          chk("kind", ok, e.kind);
          chk("cycle", cyc, e.cyc);
          chk("file_index", int'(file_index), e.file);
          chk("line_index", int'(line_index), e.line);
          chk("iteration", int'(iteration), e.iter);
          chk("busy_active", int'(busy), 1);
        end
      end else begin
        chk("busy_idle", int'(busy), 0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"},  int'(read_file), 0);
    chk({tag, "_wreg"},  int'(write_reg), 0);
    chk({tag, "_wfile"}, int'(write_file), 0);
    chk({tag, "_file"},  int'(file_index), 0);
    chk({tag, "_line"},  int'(line_index), 0);
    chk({tag, "_iter"},  int'(iteration), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
  endtask

  initial begin
    int t;
    int t2;
    rst        = 1'b1;
    start      = 1'b0;
    base_file  = '0;
    file_count = '0;
    round      = '0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // single file
    wcount = 0;
    run_start(5, 1, 3, t);
    wait_drain(400);
    chk("single_wcount", wcount, 64);

    // multi-file with wrap 1022, 1023, 0
    wcount = 0;
    run_start(1022, 3, 17, t);
    wait_drain(1000);
    chk("wrap_wcount", wcount, 192);

    // zero count: done right away, no strobes
    wcount = 0;
    run_start(40, 0, 9, t);
    wait_drain(10);
    repeat (3) @(negedge clk);
    chk("zero_wcount", wcount, 0);

    // start while busy is ignored
    run_start(100, 2, 7, t);
    repeat (50) @(negedge clk);
    base_file  = FILE_W'(9);
    file_count = FILE_W'(1);
    round      = 5'd1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(1000);
    repeat (3) @(negedge clk);

    // start held high through DONE: second batch one IDLE cycle later
    @(negedge clk);
    base_file  = FILE_W'(20);
    file_count = FILE_W'(1);
    round      = 5'd31;
    start      = 1'b1;
    t  = cyc + 1;
    t2 = t + 3 * LINES + 2;
    push_batch(t, 20, 1, 31, -1);
    push_batch(t2, 20, 1, 31, -1);
    while (cyc < t2) @(negedge clk);
    start = 1'b0;
    wait_drain(600);
    repeat (3) @(negedge clk);

    // reset while in LATCH of line 10
    wcount = 0;
    @(negedge clk);
    base_file  = FILE_W'(5);
    file_count = FILE_W'(1);
    round      = 5'd3;
    start      = 1'b1;
    t = cyc + 1;
    push_batch(t, 5, 1, 3, 32);
    @(negedge clk);
    start = 1'b0;
    while (cyc < t + 31) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    wait_drain(5);
    repeat (10) @(negedge clk);
    chk("midrst_wcount", wcount, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
